// File: rtl/core_pkg.sv
// Shared definitions for the nandgameplus core: sequencer states,
// instruction field positions and the default reset program counter.
package core_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2
   } seq_state_t;

   // Bit 15 separates compute instructions (1) from immediate loads (0)
   localparam int INSTR_COMPUTE_BIT = 15;

   // Jump condition bits inside a compute instruction
   localparam int JMP_LT_BIT = 2;
   localparam int JMP_EQ_BIT = 1;
   localparam int JMP_GT_BIT = 0;

   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

endpackage

// File: rtl/core_sequencer_jump_cond.sv
// Combinational jump resolution. It tests the ALU result as a signed value
// against the three jump-condition bits of a compute instruction. It is kept
// standalone so the pipelined core can reuse it.
module jump_cond (
   input  logic [15:0] alu_x,
   input  logic        j_lt,
   input  logic        j_eq,
   input  logic        j_gt,
   input  logic        compute,
   output logic        take
);

   logic is_neg;
   logic is_zero;
   logic is_pos;

   // Classify alu_x as negative, zero or positive, then match against the jump bits
   always_comb begin
      is_neg  = alu_x[15];
      is_zero = (alu_x == 16'h0000);
      is_pos  = !is_neg && !is_zero;
      take    = compute && ((j_lt && is_neg) || (j_eq && is_zero) || (j_gt && is_pos));
   end

endmodule

// File: rtl/core_sequencer.sv
// Fetch/execute controller for the nandgameplus core. It fetches one
// instruction over a req/ack handshake and executes it for a single cycle.
// It also owns the program counter and the retired-instruction counter.
module core_sequencer
   import core_pkg::*;
#(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run_i,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   output logic [15:0]     instr_o,
   output logic            instr_valid,
   output logic            reg_we,
   input  logic [15:0]     alu_x,
   input  logic [15:0]     jump_target,
   output logic [PC_W-1:0] pc_o,
   output logic [15:0]     retired_o,
   output logic            busy_o
);

   seq_state_t      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     instr_q, instr_d;
   logic [15:0]     retired_q, retired_d;
   logic            take;

   jump_cond u_jump_cond (
      .alu_x   (alu_x),
      .j_lt    (instr_q[JMP_LT_BIT]),
      .j_eq    (instr_q[JMP_EQ_BIT]),
      .j_gt    (instr_q[JMP_GT_BIT]),
      .compute (instr_q[INSTR_COMPUTE_BIT]),
      .take    (take)
   );

   // Next-state logic. An instruction is latched on ack in FETCH.
   // EXEC retires it and advances or redirects the program counter.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      retired_d = retired_q;
      case (state_q)
         IDLE: begin
            if (run_i) state_d = FETCH;
         end
         FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            retired_d = retired_q + 16'd1;
            pc_d      = take ? PC_W'(jump_target) : pc_q + PC_W'(1);
            state_d   = run_i ? FETCH : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= 16'h0000;
         retired_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         retired_q <= retired_d;
      end
   end

   // Strobes decode only the state flop, so they stay glitch-free and drop with reset
   assign imem_req    = (state_q == FETCH);
   assign instr_valid = (state_q == EXEC);
   assign reg_we      = (state_q == EXEC);
   assign busy_o      = (state_q != IDLE);
   assign imem_addr   = pc_q;
   assign pc_o        = pc_q;
   assign instr_o     = instr_q;
   assign retired_o   = retired_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer. A transaction-level model tracks
// the expected program counter and retired count for each instruction.
module tb_core_sequencer;

   logic        clk;
   logic        rst_n;
   logic        run_i;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic [15:0] instr_o;
   logic        instr_valid;
   logic        reg_we;
   logic [15:0] alu_x;
   logic [15:0] jump_target;
   logic [15:0] pc_o;
   logic [15:0] retired_o;
   logic        busy_o;

   int          checkCount = 0;
   int          passCount  = 0;

   logic [15:0] modelPc;
   logic [15:0] modelRetired;
   logic [15:0] lastWord;

   core_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run_i       (run_i),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr_o     (instr_o),
      .instr_valid (instr_valid),
      .reg_we      (reg_we),
      .alu_x       (alu_x),
      .jump_target (jump_target),
      .pc_o        (pc_o),
      .retired_o   (retired_o),
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      else
         passCount++;
   endtask

   // Jump rule taken directly from the instruction definition, using signed integer compares
   function automatic bit modelTake(input logic [15:0] word, input logic [15:0] ax);
      int v;
      v = int'($signed(ax));
      if (!word[15]) return 1'b0;
      return (word[2] && v < 0) || (word[1] && v == 0) || (word[0] && v > 0);
   endfunction

   // Asserts reset, checks that the outputs clear at once, then releases reset on a falling edge
   task automatic resetDut();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_req", imem_req, 1'b0);
      checkOutput("rst_we", reg_we, 1'b0);
      checkOutput("rst_valid", instr_valid, 1'b0);
      checkOutput("rst_busy", busy_o, 1'b0);
      checkOutput("rst_pc", pc_o, 16'h0000);
      checkOutput("rst_retired", retired_o, 16'h0000);
      checkOutput("rst_instr", instr_o, 16'h0000);
      run_i    = 1'b0;
      imem_ack = 1'b0;
      @(negedge clk);
      rst_n        = 1'b1;
      modelPc      = 16'h0000;
      modelRetired = 16'h0000;
      lastWord     = 16'h0000;
   endtask

   // Raises run_i from IDLE and returns on the falling edge where FETCH should be active
   task automatic startRun();
      run_i    = 1'b1;
      imem_ack = 1'b0;
      @(negedge clk);
   endtask

   // Holds the sequencer idle for n cycles with stray acks, which it must ignore
   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         run_i      = 1'b0;
         imem_ack   = 1'($urandom_range(0, 1));
         imem_rdata = 16'($urandom);
         @(negedge clk);
         checkOutput("idle_busy", busy_o, 1'b0);
         checkOutput("idle_req", imem_req, 1'b0);
         checkOutput("idle_instr", instr_o, lastWord);
         checkOutput("idle_pc", pc_o, modelPc);
      end
      imem_ack = 1'b0;
   endtask

   // Runs one fetch/execute transaction starting from a falling edge in FETCH
   task automatic applyStimulus(input logic [15:0] word, input int waits, input logic [15:0] ax,
                                input logic [15:0] jt, input bit dropRun, input bit runExec);
      checkOutput("fetch_req", imem_req, 1'b1);
      checkOutput("fetch_addr", imem_addr, modelPc);
      checkOutput("fetch_busy", busy_o, 1'b1);
      if (dropRun) run_i = 1'b0;
      for (int i = 0; i < waits; i++) begin
         imem_ack   = 1'b0;
         imem_rdata = 16'($urandom);
         @(negedge clk);
         checkOutput("wait_req", imem_req, 1'b1);
         checkOutput("wait_addr", imem_addr, modelPc);
         checkOutput("wait_valid", instr_valid, 1'b0);
      end
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      checkOutput("exec_valid", instr_valid, 1'b1);
      checkOutput("exec_we", reg_we, 1'b1);
      checkOutput("exec_instr", instr_o, word);
      checkOutput("exec_req", imem_req, 1'b0);
      alu_x       = ax;
      jump_target = jt;
      run_i       = runExec;
      imem_ack    = 1'($urandom_range(0, 1));
      imem_rdata  = 16'($urandom);
      modelPc      = modelTake(word, ax) ? jt : modelPc + 16'd1;
      modelRetired = modelRetired + 16'd1;
      lastWord     = word;
      @(negedge clk);
      imem_ack = 1'b0;
      checkOutput("post_pc", pc_o, modelPc);
      checkOutput("post_retired", retired_o, modelRetired);
      checkOutput("post_valid", instr_valid, 1'b0);
      checkOutput("post_we", reg_we, 1'b0);
      checkOutput("post_instr", instr_o, word);
      checkOutput("post_busy", busy_o, runExec);
      checkOutput("post_req", imem_req, runExec);
   endtask

   initial begin
      logic [15:0] word;
      logic [15:0] ax;
      logic [15:0] jt;
      bit          runExec;

      rst_n       = 1'b0;
      run_i       = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 16'h0000;
      alu_x       = 16'h0000;
      jump_target = 16'h0000;
      @(negedge clk);
      resetDut();

      // First instruction with a zero-wait memory
      startRun();
      applyStimulus(16'h1234, 0, 16'h5555, 16'hAAAA, 1'b0, 1'b1);
      // Three-cycle ack delay
      applyStimulus(16'h0042, 3, 16'h0000, 16'h0000, 1'b0, 1'b1);
      // Unconditional jump, then a not-taken less-than, then a taken less-than
      applyStimulus(16'h8007, 0, 16'h0000, 16'h0040, 1'b0, 1'b1);
      applyStimulus(16'h8004, 1, 16'h0005, 16'h1111, 1'b0, 1'b1);
      applyStimulus(16'h8004, 0, 16'hFFFF, 16'h0200, 1'b0, 1'b1);
      // Self-loop jump, then a never-jump with a matching condition value
      applyStimulus(16'h8002, 0, 16'h0000, modelPc, 1'b0, 1'b1);
      applyStimulus(16'h8000, 0, 16'h0000, 16'h3333, 1'b0, 1'b1);
      // An immediate load with jump-like low bits must not jump
      applyStimulus(16'h0007, 0, 16'h0000, 16'h4444, 1'b0, 1'b1);
      // PC wrap: jump to FFFF, then execute a plain instruction
      applyStimulus(16'h8001, 0, 16'h0001, 16'hFFFF, 1'b0, 1'b1);
      applyStimulus(16'h0005, 0, 16'h0000, 16'h0000, 1'b0, 1'b1);
      // run_i dropped mid-fetch: the instruction completes, then the sequencer parks
      applyStimulus(16'h0777, 2, 16'h0000, 16'h0000, 1'b1, 1'b0);
      idleCycles(3);

      // Reset while a fetch is pending
      startRun();
      checkOutput("midfetch_req", imem_req, 1'b1);
      resetDut();
      // Reset during EXEC: the aborted instruction is not counted
      startRun();
      imem_ack   = 1'b1;
      imem_rdata = 16'hBEEF;
      @(negedge clk);
      checkOutput("midexec_we", reg_we, 1'b1);
      resetDut();

      // Randomized instruction stream
      startRun();
      for (int n = 0; n < 300; n++) begin
         word = 16'($urandom);
         case ($urandom_range(0, 3))
            0:       ax = 16'h0000;
            1:       ax = 16'($urandom);
            2:       ax = 16'h8000 | 16'($urandom);
            default: ax = 16'($urandom_range(1, 3));
         endcase
         jt      = ($urandom_range(0, 7) == 0) ? modelPc : 16'($urandom);
         runExec = ($urandom_range(0, 7) != 0);
         applyStimulus(word, $urandom_range(0, 3), ax, jt, 1'b0, runExec);
         if (!runExec) begin
            idleCycles($urandom_range(0, 2));
            startRun();
         end
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
